// File: rtl/hash_result_scan.sv
// hash_result_scan: reads back NUM_NONCES H0 words, tracks the minimum and its index, counts hits below
// target, then writes a summary record. Define HIT_BITMAP_EN to add hit_map and the bitmap record words.
module hash_result_scan #(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           hash_addr,
  input  logic [15:0]           result_addr,
  input  logic [31:0]           target,
  output logic                  done,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic [31:0]           min_hash,
  output logic [15:0]           min_idx,
`ifdef HIT_BITMAP_EN
  output logic [15:0]           hit_count,
  output logic [NUM_NONCES-1:0] hit_map
`else
  output logic [15:0]           hit_count
`endif
);
`ifdef HIT_BITMAP_EN
  localparam int BM_WORDS  = (NUM_NONCES + 31) / 32;
  localparam int PAD_W     = BM_WORDS * 32;
  localparam int NUM_WORDS = 3 + BM_WORDS;
`else
  localparam int NUM_WORDS = 3;
`endif
  localparam logic [16:0] N_CNT     = 17'(NUM_NONCES);
  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [16:0]      rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;
  logic [15:0]      hash_base_q, hash_base_d;
  logic [15:0]      res_base_q, res_base_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      min_q, min_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      hits_q, hits_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             do_cmp;
  logic             cmp_take, cmp_hit;
  logic [31:0]      cmp_min;
  logic [IDX_W-1:0] cmp_idx;
  logic [15:0]      cmp_hits;
  logic [15:0]      word_sel;
  logic [31:0]      next_word;

`ifdef HIT_BITMAP_EN
  logic [NUM_NONCES-1:0] map_q, map_d;
  logic [PAD_W-1:0]      map_pad;
  logic [15:0]           bm_sel;
  assign map_pad = PAD_W'(map_q);
  assign bm_sel  = wr_cnt_q - 16'd2;
  assign hit_map = map_q;
`endif

  // Index 0 always loads so the first word seeds the minimum; strict < keeps the lower index on ties.
  always_comb begin
    cmp_take = (cmp_cnt_q == '0) || (mem_read_data < min_q);
    cmp_hit  = mem_read_data < target_q;
    cmp_min  = cmp_take ? mem_read_data : min_q;
    cmp_idx  = cmp_take ? cmp_cnt_q : idx_q;
    cmp_hits = (cmp_hit && hits_q != 16'hFFFF) ? hits_q + 16'd1 : hits_q;
  end

  // Record word following the one currently on the bus.
  always_comb begin
    word_sel  = wr_cnt_q + 16'd1;
    next_word = 32'h0;
    case (word_sel)
      16'd1:   next_word = {16'h0, 16'(idx_q)};
      16'd2:   next_word = {(hits_q != 16'h0), 15'h0, hits_q};
`ifdef HIT_BITMAP_EN
      default: next_word = map_pad[32*int'(bm_sel) +: 32];
`else
      default: next_word = 32'h0;
`endif
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    cmp_cnt_d   = cmp_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    hash_base_d = hash_base_q;
    res_base_d  = res_base_q;
    target_d    = target_q;
    min_d       = min_q;
    idx_d       = idx_q;
    hits_d      = hits_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    do_cmp      = 1'b0;
`ifdef HIT_BITMAP_EN
    map_d       = map_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          hash_base_d = hash_addr;
          res_base_d  = result_addr;
          target_d    = target;
          addr_d      = hash_addr;
          rd_cnt_d    = 17'd1;
          cmp_cnt_d   = '0;
          min_d       = 32'hFFFF_FFFF;
          idx_d       = '0;
          hits_d      = 16'h0;
`ifdef HIT_BITMAP_EN
          map_d       = '0;
`endif
          state_d     = READ;
        end
      end
      READ: begin
        do_cmp = (rd_cnt_q > 17'd1);
        if (rd_cnt_q < N_CNT) begin
          addr_d   = hash_base_q + rd_cnt_q[15:0];
          rd_cnt_d = rd_cnt_q + 17'd1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        do_cmp   = 1'b1;
        we_d     = 1'b1;
        addr_d   = res_base_q;
        wdata_d  = cmp_min;
        wr_cnt_d = 16'd0;
        state_d  = WRITE;
      end
      WRITE: begin
        if (wr_cnt_q == LAST_WORD) begin
          state_d = DONE;
        end else begin
          we_d     = 1'b1;
          wr_cnt_d = word_sel;
          addr_d   = res_base_q + word_sel;
          wdata_d  = next_word;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_cmp) begin
      min_d     = cmp_min;
      idx_d     = cmp_idx;
      hits_d    = cmp_hits;
      cmp_cnt_d = cmp_cnt_q + IDX_W'(1);
`ifdef HIT_BITMAP_EN
      map_d[cmp_cnt_q] = cmp_hit;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      cmp_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      hash_base_q <= '0;
      res_base_q  <= '0;
      target_q    <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      hits_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef HIT_BITMAP_EN
      map_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      hash_base_q <= hash_base_d;
      res_base_q  <= res_base_d;
      target_q    <= target_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      hits_q      <= hits_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef HIT_BITMAP_EN
      map_q       <= map_d;
`endif
    end
  end

  assign done           = (state_q == DONE);
  assign mem_clk        = clk;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign min_hash       = min_q;
  assign min_idx        = 16'(idx_q);
  assign hit_count      = hits_q;

endmodule

// File: tb/tb_hash_result_scan.sv
// Bench for hash_result_scan: directed and randomized scans against a memory model and a
// reference computed straight from the array contents.
module tb_hash_result_scan;
  localparam int N = 16;
`ifdef HIT_BITMAP_EN
  localparam int LAT = N + 6;
`else
  localparam int LAT = N + 5;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = 16'h0;
  logic [15:0] result_addr = 16'h0;
  logic [31:0] target = 32'h0;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] min_hash;
  logic [15:0] min_idx, hit_count;
`ifdef HIT_BITMAP_EN
  logic [N-1:0] hit_map;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] h [N];

  hash_result_scan #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
    .done(done), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .min_hash(min_hash), .min_idx(min_idx),
`ifdef HIT_BITMAP_EN
    .hit_count(hit_count), .hit_map(hit_map)
`else
    .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [15:0] hb, input logic [15:0] rb, input logic [31:0] tg,
                          input bit hold, input bit pulse, input string name);
    logic [31:0] exp_min;
    logic [15:0] exp_idx, exp_hits;
    logic [15:0] seq[$];
    bit          seen_we;
    int          edges;
    // Reference: minimum value, lowest index holding it, count below target.
    exp_min = h[0];
    for (int i = 1; i < N; i++) if (h[i] < exp_min) exp_min = h[i];
    exp_idx = 16'hFFFF;
    for (int i = N - 1; i >= 0; i--) if (h[i] == exp_min) exp_idx = 16'(i);
    exp_hits = 16'h0;
    for (int i = 0; i < N; i++) if (h[i] < tg) exp_hits++;

    for (int i = 0; i < N; i++) mem[hb + 16'(i)] <= h[i];
    for (int i = 0; i < LAT; i++) mem[rb + 16'(i % 4)] <= 32'hDEAD_BEEF;
    @(negedge clk);
    hash_addr = hb; result_addr = rb; target = tg; start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    hash_addr = 16'($urandom); result_addr = 16'($urandom); target = $urandom;
    check({name, "/done_clear"}, {31'h0, done}, 32'h0);
    seq.delete();
    seq.push_back(mem_addr);
    seen_we = 1'b0;
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (hold) start = (edges < 3);
      else if (pulse) start = ((edges % 3) == 1) && (edges < N - 2);
      if (mem_we) seen_we = 1'b1;
      else if (!seen_we && mem_addr != seq[$]) seq.push_back(mem_addr);
    end
    start = 1'b0;
    check({name, "/latency"}, 32'(edges + 1), 32'(LAT));
    check({name, "/min_hash"}, min_hash, exp_min);
    check({name, "/min_idx"}, {16'h0, min_idx}, {16'h0, exp_idx});
    check({name, "/hit_count"}, {16'h0, hit_count}, {16'h0, exp_hits});
    check({name, "/we_idle"}, {31'h0, mem_we}, 32'h0);
    check({name, "/rec0"}, mem[rb], exp_min);
    check({name, "/rec1"}, mem[rb + 16'd1], {16'h0, exp_idx});
    check({name, "/rec2"}, mem[rb + 16'd2], {(exp_hits != 16'h0), 15'h0, exp_hits});
`ifdef HIT_BITMAP_EN
    begin
      logic [31:0] bm;
      bm = 32'h0;
      for (int i = 0; i < N; i++) bm[i] = (h[i] < tg);
      check({name, "/rec3"}, mem[rb + 16'd3], bm);
    end
`endif
    check({name, "/rd_count"}, 32'(seq.size()), 32'(N));
    for (int i = 0; i < N && i < seq.size(); i++)
      check($sformatf("%s/rd_addr%0d", name, i), {16'h0, seq[i]}, {16'h0, hb + 16'(i)});
    $display("[TB] scan %s: min=%h idx=%0d hits=%0d edges=%0d", name, min_hash, min_idx, hit_count, edges + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      h[i] = (32'($urandom_range(0, 3)) << 30) | 32'($urandom_range(0, 5));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst/done", {31'h0, done}, 32'h0);
    check("rst/mem_we", {31'h0, mem_we}, 32'h0);
    check("rst/mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst/mem_wdata", mem_write_data, 32'h0);
    check("rst/min_hash", min_hash, 32'h0);
    check("rst/min_idx", {16'h0, min_idx}, 32'h0);
    check("rst/hit_count", {16'h0, hit_count}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < N; i++) h[i] = 32'(32'h1000_0000 * (16 - i));
    run_scan(16'h0100, 16'h0800, 32'h3000_0000, 1'b0, 1'b0, "descending");

    for (int i = 0; i < N; i++) h[i] = 32'h0000_1234;
    h[3] = 32'h5; h[9] = 32'h5;
    run_scan(16'h0200, 16'h0810, 32'h0000_0006, 1'b0, 1'b0, "ties");

    for (int i = 0; i < N; i++) h[i] = 32'hFFFF_FFFF;
    run_scan(16'h0300, 16'h0820, 32'h0, 1'b0, 1'b0, "target0");

    fill_random();
    h[2] = 32'hFFFF_FFFF; h[7] = 32'hFFFF_FFFF;
    run_scan(16'h0340, 16'h0820, 32'hFFFF_FFFF, 1'b0, 1'b0, "target_max");

    fill_random();
    run_scan(16'hFFF8, 16'h2000, $urandom, 1'b0, 1'b0, "hash_wrap");

    fill_random();
    run_scan(16'h0400, 16'hFFFF, $urandom, 1'b0, 1'b0, "result_wrap");

    // Asynchronous reset in the middle of READ.
    fill_random();
    for (int i = 0; i < N; i++) mem[16'h4000 + 16'(i)] <= h[i];
    @(negedge clk);
    hash_addr = 16'h4000; result_addr = 16'h0840; target = 32'h8000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst/done", {31'h0, done}, 32'h0);
    check("midrst/mem_we", {31'h0, mem_we}, 32'h0);
    check("midrst/mem_addr", {16'h0, mem_addr}, 32'h0);
    check("midrst/min_hash", min_hash, 32'h0);
    check("midrst/min_idx", {16'h0, min_idx}, 32'h0);
    check("midrst/hit_count", {16'h0, hit_count}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) h[i] = 32'h7000_0000 + 32'(N - i);
    run_scan(16'h4100, 16'h0840, 32'h7000_0003, 1'b0, 1'b0, "after_reset");

    // Back-to-back into the same record; start pulses during READ must be ignored.
    fill_random();
    run_scan(16'h0500, 16'h0860, 32'h0, 1'b0, 1'b1, "b2b_first");
    run_scan(16'h0500, 16'h0860, 32'hFFFF_FFFF, 1'b1, 1'b0, "b2b_second");

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_scan(16'(16'h1000 + 16'(r * 64)), 16'(16'h0900 + 16'(r * 8)), $urandom,
               1'b0, 1'(r % 2), $sformatf("random%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
